state_event_logger: RTL and testbench

- Downstream consumer of the two-flip-flop sequential circuit's state outputs (F1, F2).
- Samples the 2-bit state {f1,f2} every enabled clock and detects each state change.
- On each change, logs an event into a small FIFO: previous state, new state, and how many samples the previous state was held.
- The bench or later logic drains events through a valid/ready read port.

---
 rtl/state_event_logger.sv | 185 ++++++++++++++++++
 tb/tb_state_event_logger.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/state_event_logger.sv
// state_event_logger: watches the 2-bit state {f1,f2} of an upstream two-flop
// machine. Each state change is logged into a small FIFO as {previous state,
// new state, samples spent in the previous state}. Events are drained through
// a valid/ready read port. The overflow flag is sticky and records any event
// dropped while the FIFO was full.
module state_event_logger #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f1,
    input  logic                       f2,
    input  logic                       en,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [1:0]                 rd_prev,
    output logic [1:0]                 rd_curr,
    output logic [CNT_W-1:0]           rd_dwell,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_OUT_W = $clog2(DEPTH+1);

    localparam logic [CNT_OUT_W-1:0] FULL_C    = CNT_OUT_W'(DEPTH);
    localparam logic [CNT_OUT_W-1:0] EMPTY_C   = {CNT_OUT_W{1'b0}};
    localparam logic [CNT_OUT_W-1:0] CNT_ONE_C = CNT_OUT_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE_C = PTR_W'(1);
    localparam logic [CNT_W-1:0]     DWELL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     DWELL_ONE = CNT_W'(1);

    // Sampler state
    logic [1:0]           last_state_r;
    logic [CNT_W-1:0]     dwell_r;

    // FIFO storage and bookkeeping
    logic [1:0]           mem_prev_r  [DEPTH];
    logic [1:0]           mem_curr_r  [DEPTH];
    logic [CNT_W-1:0]     mem_dwell_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_OUT_W-1:0] count_r;
    logic                 overflow_r;

    // Combinational control
    logic [1:0]           sample_s;
    logic                 change_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 push_s;
    logic                 drop_s;
    logic [CNT_W-1:0]     dwell_inc_s;

    // Decode change/push/pop/drop decisions from the current sample and FIFO state
    always_comb begin
        sample_s    = {f1, f2};
        change_s    = 1'b0;
        pop_s       = 1'b0;
        full_s      = 1'b0;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        dwell_inc_s = dwell_r;

        if (en && (sample_s != last_state_r)) begin
            change_s = 1'b1;
        end else begin
            change_s = 1'b0;
        end

        if ((count_r != EMPTY_C) && rd_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        if (count_r == FULL_C) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end

        // A full FIFO still accepts a push when a pop frees the head slot this edge
        if (change_s && (!full_s || pop_s)) begin
            push_s = 1'b1;
            drop_s = 1'b0;
        end else if (change_s) begin
            push_s = 1'b0;
            drop_s = 1'b1;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end

        // Dwell saturates instead of wrapping so long holds read as "at least max"
        if (dwell_r != DWELL_MAX) begin
            dwell_inc_s = dwell_r + DWELL_ONE;
        end else begin
            dwell_inc_s = dwell_r;
        end
    end

    // Track the last sampled state and how long it has been held
    always_ff @(posedge clk) begin
        if (reset) begin
            last_state_r <= 2'b00;
            dwell_r      <= {CNT_W{1'b0}};
        end else if (change_s) begin
            last_state_r <= sample_s;
            dwell_r      <= DWELL_ONE;
        end else if (en) begin
            last_state_r <= last_state_r;
            dwell_r      <= dwell_inc_s;
        end else begin
            last_state_r <= last_state_r;
            dwell_r      <= dwell_r;
        end
    end

    // Write accepted events into storage; reset clears every entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_prev_r[i]  <= 2'b00;
                mem_curr_r[i]  <= 2'b00;
                mem_dwell_r[i] <= {CNT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_prev_r[wr_ptr_r]  <= last_state_r;
            mem_curr_r[wr_ptr_r]  <= sample_s;
            mem_dwell_r[wr_ptr_r] <= dwell_r;
        end else begin
            mem_prev_r[wr_ptr_r]  <= mem_prev_r[wr_ptr_r];
            mem_curr_r[wr_ptr_r]  <= mem_curr_r[wr_ptr_r];
            mem_dwell_r[wr_ptr_r] <= mem_dwell_r[wr_ptr_r];
        end
    end

    // Advance pointers (wrapping naturally at power-of-two DEPTH) and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= EMPTY_C;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for any event lost to a full FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign rd_valid = (count_r != EMPTY_C);
    assign rd_prev  = mem_prev_r[rd_ptr_r];
    assign rd_curr  = mem_curr_r[rd_ptr_r];
    assign rd_dwell = mem_dwell_r[rd_ptr_r];
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_state_event_logger.sv
// Bench for state_event_logger: directed stimulus, a queue-based event model
// compared against the DUT on every falling edge, and literal expectations at
// the key points of each scenario.
module tb_state_event_logger;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       f1 = 1'b0;
    logic       f2 = 1'b0;
    logic       en = 1'b0;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [1:0] rd_prev;
    logic [1:0] rd_curr;
    logic [7:0] rd_dwell;
    logic [2:0] count;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    state_event_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .f1       (f1),
        .f2       (f2),
        .en       (en),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_prev  (rd_prev),
        .rd_curr  (rd_curr),
        .rd_dwell (rd_dwell),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0] p;
        logic [1:0] c;
        logic [7:0] d;
    } ev_t;

    ev_t m_q[$];
    int  m_last = 0;
    int  m_dwell = 0;
    bit  m_ovf = 1'b0;

    always @(posedge clk) begin
        int  s;
        bit  pop;
        ev_t e;
        s = {f1, f2};
        if (reset) begin
            m_q.delete();
            m_last  = 0;
            m_dwell = 0;
            m_ovf   = 1'b0;
        end else begin
            pop = (m_q.size() != 0) && rd_ready;
            if (pop) void'(m_q.pop_front());
            if (en && s != m_last) begin
                e.p = 2'(m_last);
                e.c = 2'(s);
                e.d = 8'(m_dwell);
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else m_ovf = 1'b1;
                m_last  = s;
                m_dwell = 1;
            end else if (en) begin
                m_dwell = (m_dwell >= 255) ? 255 : m_dwell + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_count", 32'(count), 32'(m_q.size()));
            chk("m_valid", 32'(rd_valid), 32'(m_q.size() != 0));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            if (m_q.size() != 0) begin
                chk("m_prev", 32'(rd_prev), 32'(m_q[0].p));
                chk("m_curr", 32'(rd_curr), 32'(m_q[0].c));
                chk("m_dwell", 32'(rd_dwell), 32'(m_q[0].d));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [1:0] s, input logic e, input logic r);
        {f1, f2} = s;
        en       = e;
        rd_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string name, input logic [1:0] p, input logic [1:0] c, input logic [7:0] d);
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_prev"}, 32'(rd_prev), 32'(p));
        chk({name, "_curr"}, 32'(rd_curr), 32'(c));
        chk({name, "_dwell"}, 32'(rd_dwell), 32'(d));
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'({rd_prev, rd_curr, rd_dwell}), 32'd0);

        // Basic event: 00 for 3 edges then 01
        for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        chk("basic_count", 32'(count), 32'd1);
        head("basic", 2'b00, 2'b01, 8'd3);

        // Drain: hold 01 two more edges, then 11, then pop twice
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        chk("drain_count2", 32'(count), 32'd2);
        step(2'b11, 1'b1, 1'b1);
        chk("drain_count1", 32'(count), 32'd1);
        head("drain2", 2'b01, 2'b11, 8'd3);
        step(2'b11, 1'b1, 1'b1);
        chk("drain_count0", 32'(count), 32'd0);
        chk("drain_valid0", 32'(rd_valid), 32'd0);

        // Saturation: 10 held for 300 edges, then 00
        step(2'b10, 1'b1, 1'b0);
        head("sat_first", 2'b11, 2'b10, 8'd3);
        for (int i = 0; i < 300; i++) step(2'b10, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        chk("sat_count", 32'(count), 32'd2);
        step(2'b00, 1'b1, 1'b1);
        head("sat", 2'b10, 2'b00, 8'd255);
        step(2'b00, 1'b1, 1'b1);
        chk("sat_empty", 32'(count), 32'd0);

        // Overflow: 5 changes into a 4-deep FIFO
        step(2'b01, 1'b1, 1'b0);
        step(2'b10, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        chk("ovf_pre", 32'(overflow), 32'd0);
        step(2'b01, 1'b1, 1'b0);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        head("ovf_oldest", 2'b00, 2'b01, 8'd3);
        // Simultaneous push and pop at full
        step(2'b10, 1'b1, 1'b1);
        chk("pp_count", 32'(count), 32'd4);
        head("pp_head", 2'b01, 2'b10, 8'd1);
        for (int i = 0; i < 3; i++) step(2'b10, 1'b1, 1'b1);
        head("pp_tail", 2'b01, 2'b10, 8'd1);
        step(2'b10, 1'b1, 1'b1);
        chk("pp_empty", 32'(count), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Enable gating
        step(2'b00, 1'b1, 1'b0);
        head("gate_pre", 2'b10, 2'b00, 8'd5);
        step(2'b00, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        chk("gate_none", 32'(count), 32'd0);
        step(2'b10, 1'b1, 1'b0);
        chk("gate_count", 32'(count), 32'd1);
        head("gate", 2'b00, 2'b10, 8'd3);

        // Mid-operation reset with count=2 and overflow set
        step(2'b11, 1'b1, 1'b0);
        chk("mr_count_pre", 32'(count), 32'd2);
        chk("mr_ovf_pre", 32'(overflow), 32'd1);
        reset = 1'b1;
        step(2'b11, 1'b1, 1'b1);
        reset = 1'b0;
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_valid", 32'(rd_valid), 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);
        chk("mr_data", 32'({rd_prev, rd_curr, rd_dwell}), 32'd0);
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        head("mr_after", 2'b00, 2'b01, 8'd2);

        step(2'b01, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
